// File: rtl/xc_integration_ctrl.sv
// Integration-frame sequencer for a correlator counter bank: clear, count for a
// programmed length, snapshot, then stream the snapshot out over valid/ready.
module xc_integration_ctrl #(
  parameter int unsigned NUM_COUNTERS = 8,
  parameter int unsigned RESOLUTION   = 32,
  parameter int unsigned TIMER_WIDTH  = 24,
  parameter int unsigned INDEX_WIDTH  = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               stop,
  input  logic                               continuous,
  input  logic [TIMER_WIDTH-1:0]             integration_len,
  input  logic [NUM_COUNTERS*RESOLUTION-1:0] counters_in,
  output logic                               counter_clear,
  output logic                               count_en,
  output logic [RESOLUTION-1:0]              out_data,
  output logic [INDEX_WIDTH-1:0]             out_index,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               frame_done,
  output logic                               busy,
  output logic                               overrun
);

  localparam int unsigned LAST_INDEX = NUM_COUNTERS - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_INTEGRATE,
    ST_LATCH
  } state_t;

  state_t                   state;
  logic [TIMER_WIDTH-1:0]   len_q;
  logic [TIMER_WIDTH-1:0]   timer;
  logic                     cont_q;
  logic [RESOLUTION-1:0]    shadow [NUM_COUNTERS];

  logic                     start_ok;
  logic                     snap_take;
  logic                     handshake;
  logic                     last_word;
  logic [INDEX_WIDTH-1:0]   next_index;

  // out_valid doubles as the dump-engine active flag
  assign start_ok   = start && !stop && !busy && (integration_len != '0);
  assign snap_take  = (state == ST_LATCH) && !out_valid;
  assign handshake  = out_valid && out_ready;
  assign last_word  = (out_index == INDEX_WIDTH'(LAST_INDEX));
  assign next_index = out_index + INDEX_WIDTH'(1);
  assign busy       = (state != ST_IDLE) || out_valid;
  assign frame_done = handshake && last_word;

  // Control FSM with registered bank controls
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      len_q         <= '0;
      timer         <= '0;
      cont_q        <= 1'b0;
      counter_clear <= 1'b0;
      count_en      <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      counter_clear <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            len_q         <= integration_len;
            cont_q        <= continuous;
            counter_clear <= 1'b1;
            state         <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (stop) begin
            cont_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            timer    <= len_q;
            count_en <= 1'b1;
            state    <= ST_INTEGRATE;
          end
        end
        ST_INTEGRATE: begin
          if (stop) begin
            cont_q   <= 1'b0;
            count_en <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            timer <= timer - TIMER_WIDTH'(1);
            if (timer == TIMER_WIDTH'(1)) begin
              count_en <= 1'b0;
              state    <= ST_LATCH;
            end
          end
        end
        ST_LATCH: begin
          // A dump still in flight means this snapshot is lost
          if (out_valid) begin
            overrun <= 1'b1;
          end
          if (cont_q && !stop) begin
            counter_clear <= 1'b1;
            state         <= ST_CLEAR;
          end else begin
            cont_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          count_en <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  // Snapshot storage; contents are only meaningful while a dump is active
  always_ff @(posedge clk) begin
    if (reset && snap_take) begin
      for (int unsigned k = 0; k < NUM_COUNTERS; k++) begin
        shadow[k] <= counters_in[k*RESOLUTION +: RESOLUTION];
      end
    end
  end

  // Dump engine: word 0 is loaded straight from the bank at snapshot time
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else if (snap_take) begin
      out_valid <= 1'b1;
      out_data  <= counters_in[RESOLUTION-1:0];
      out_index <= '0;
    end else if (handshake) begin
      if (last_word) begin
        out_valid <= 1'b0;
      end else begin
        out_index <= next_index;
        out_data  <= shadow[next_index];
      end
    end
  end

endmodule
